// File: rtl/nh_lcd_sequencer.sv
// nh_lcd_sequencer
//
// Bring-up and frame-write sequencer for the NH LCD byte-wide command path.
// A start pulse optionally pulses the panel reset, plays a host-loaded init
// script (command / parameter / delay / end entries), programs the column and
// page window, issues memory-write and then hands the bus to the pixel data
// writer until the frame-end pulse arrives.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_start               begin a sequence (ignored while o_busy)
//   i_frame_only          sampled with i_start: skip reset and script
//   i_script_we/addr/data script RAM write port; entry = {op[1:0], byte[7:0]}
//                         op 00 cmd, 01 param, 10 delay (byte*256 cycles), 11 end
//   i_width, i_height     frame size in pixels, sampled with i_start
//   i_frame_end           frame pixels delivered (only honoured while streaming)
//   o_busy, o_done        sequence active / one-cycle completion pulse
//   o_error               sticky timeout or zero-dimension flag
//   o_reset_display       panel reset to the datapath
//   o_data_command_mode   1 while the pixel data writer owns the bus
//   o_cmd_write_stb       one-cycle byte strobe; o_cmd_rs/o_cmd_data hold after
//   i_cmd_finished        datapath byte-complete handshake
//   o_num_pixels          width*height latched at the accepted start
//
// RESET_CYCLES and WAKE_CYCLES must be at least 1.

module nh_lcd_sequencer #(
    parameter int unsigned RESET_CYCLES   = 100,
    parameter int unsigned WAKE_CYCLES    = 1000,
    parameter int unsigned SCRIPT_AW      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_frame_only,
    input  logic                 i_script_we,
    input  logic [SCRIPT_AW-1:0] i_script_addr,
    input  logic [9:0]           i_script_data,
    input  logic [15:0]          i_width,
    input  logic [15:0]          i_height,
    input  logic                 i_frame_end,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic                 o_reset_display,
    output logic                 o_data_command_mode,
    output logic                 o_cmd_write_stb,
    output logic                 o_cmd_rs,
    output logic [7:0]           o_cmd_data,
    input  logic                 i_cmd_finished,
    output logic [31:0]          o_num_pixels
);

    localparam int unsigned ScriptDepth = 2 ** SCRIPT_AW;

    localparam logic [1:0] OpCmd   = 2'b00;
    localparam logic [1:0] OpParam = 2'b01;
    localparam logic [1:0] OpDelay = 2'b10;
    localparam logic [1:0] OpEnd   = 2'b11;

    // Index of the last window byte (0x2C memory-write).
    localparam logic [3:0] WinLast = 4'd10;

    typedef enum logic [3:0] {
        StIdle,
        StZeroDim,
        StRstAssert,
        StRstWait,
        StFetch,
        StDecode,
        StCmdWait,
        StDelay,
        StWinIssue,
        StWinWait,
        StStream
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [SCRIPT_AW-1:0] ptr_q, ptr_d;
    logic [3:0]           win_idx_q, win_idx_d;
    logic [15:0]          width_q, width_d;
    logic [15:0]          height_q, height_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 reset_display_q, reset_display_d;
    logic                 dcm_q, dcm_d;
    logic                 stb_q, stb_d;
    logic                 rs_q, rs_d;
    logic [7:0]           data_q, data_d;
    logic [31:0]          num_pixels_q, num_pixels_d;

    // ------------------------------------------------------------------
    // Script RAM: synchronous read, read-before-write on an address clash.
    // Contents deliberately survive rst.
    // ------------------------------------------------------------------
    logic [9:0] script_mem [ScriptDepth];
    logic [9:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (i_script_we) begin
            script_mem[i_script_addr] <= i_script_data;
        end
        rd_data_q <= script_mem[ptr_q];
    end

    logic [1:0] rd_op;
    logic [7:0] rd_byte;
    assign rd_op   = rd_data_q[9:8];
    assign rd_byte = rd_data_q[7:0];

    // ------------------------------------------------------------------
    // Window byte table: CASET, PASET (start 0, end = size-1), RAMWR.
    // ------------------------------------------------------------------
    logic [15:0] w_last;
    logic [15:0] h_last;
    logic [7:0]  win_byte;
    logic        win_rs;

    assign w_last = width_q - 16'd1;
    assign h_last = height_q - 16'd1;

    always_comb begin
        win_byte = 8'h00;
        win_rs   = 1'b1;
        case (win_idx_q)
            4'd0: begin
                win_byte = 8'h2A;
                win_rs   = 1'b0;
            end
            4'd3:  win_byte = w_last[15:8];
            4'd4:  win_byte = w_last[7:0];
            4'd5: begin
                win_byte = 8'h2B;
                win_rs   = 1'b0;
            end
            4'd8:  win_byte = h_last[15:8];
            4'd9:  win_byte = h_last[7:0];
            4'd10: begin
                win_byte = 8'h2C;
                win_rs   = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake qualifiers shared by the script and window byte waits.
    // A finished seen in the strobe cycle belongs to the previous byte.
    // ------------------------------------------------------------------
    logic fin_ok;
    logic timed_out;
    logic ptr_last;

    assign fin_ok    = i_cmd_finished && !stb_q;
    assign timed_out = (cnt_q == TIMEOUT_CYCLES);
    assign ptr_last  = &ptr_q;

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ptr_d           = ptr_q;
        win_idx_d       = win_idx_q;
        width_d         = width_q;
        height_d        = height_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        error_d         = error_q;
        reset_display_d = reset_display_q;
        dcm_d           = dcm_q;
        stb_d           = 1'b0;
        rs_d            = rs_q;
        data_d          = data_q;
        num_pixels_d    = num_pixels_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    width_d      = i_width;
                    height_d     = i_height;
                    num_pixels_d = 32'(i_width) * 32'(i_height);
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = 32'd0;
                    ptr_d        = '0;
                    win_idx_d    = 4'd0;
                    if (i_width == 16'd0 || i_height == 16'd0) begin
                        state_d = StZeroDim;
                    end else if (i_frame_only) begin
                        state_d = StWinIssue;
                    end else begin
                        reset_display_d = 1'b1;
                        state_d         = StRstAssert;
                    end
                end
            end

            StZeroDim: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            StRstAssert: begin
                if (cnt_q == RESET_CYCLES - 1) begin
                    reset_display_d = 1'b0;
                    cnt_d           = 32'd0;
                    state_d         = StRstWait;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StRstWait: begin
                if (cnt_q == WAKE_CYCLES - 1) begin
                    ptr_d   = '0;
                    state_d = StFetch;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // RAM address is ptr_q; data appears in rd_data_q next cycle.
            StFetch: begin
                state_d = StDecode;
            end

            StDecode: begin
                unique case (rd_op)
                    OpCmd, OpParam: begin
                        stb_d   = 1'b1;
                        data_d  = rd_byte;
                        rs_d    = rd_op[0];
                        cnt_d   = 32'd0;
                        state_d = StCmdWait;
                    end
                    OpDelay: begin
                        if (rd_byte == 8'd0) begin
                            ptr_d   = ptr_last ? ptr_q : ptr_q + SCRIPT_AW'(1);
                            state_d = ptr_last ? StWinIssue : StFetch;
                        end else begin
                            // Down-counter: the state lasts exactly byte*256 cycles.
                            cnt_d   = {16'h0000, rd_byte, 8'h00};
                            state_d = StDelay;
                        end
                    end
                    OpEnd: begin
                        state_d = StWinIssue;
                    end
                    default: state_d = StWinIssue;
                endcase
            end

            StCmdWait: begin
                if (fin_ok) begin
                    // Running off the end of the RAM falls through to the window.
                    ptr_d   = ptr_last ? ptr_q : ptr_q + SCRIPT_AW'(1);
                    state_d = ptr_last ? StWinIssue : StFetch;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StDelay: begin
                if (cnt_q == 32'd1) begin
                    ptr_d   = ptr_last ? ptr_q : ptr_q + SCRIPT_AW'(1);
                    state_d = ptr_last ? StWinIssue : StFetch;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end

            StWinIssue: begin
                stb_d   = 1'b1;
                data_d  = win_byte;
                rs_d    = win_rs;
                cnt_d   = 32'd0;
                state_d = StWinWait;
            end

            StWinWait: begin
                if (fin_ok) begin
                    if (win_idx_q == WinLast) begin
                        dcm_d   = 1'b1;
                        state_d = StStream;
                    end else begin
                        win_idx_d = win_idx_q + 4'd1;
                        state_d   = StWinIssue;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StStream: begin
                if (i_frame_end) begin
                    dcm_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= 32'd0;
            ptr_q           <= '0;
            win_idx_q       <= 4'd0;
            width_q         <= 16'd0;
            height_q        <= 16'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            reset_display_q <= 1'b0;
            dcm_q           <= 1'b0;
            stb_q           <= 1'b0;
            rs_q            <= 1'b0;
            data_q          <= 8'd0;
            num_pixels_q    <= 32'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ptr_q           <= ptr_d;
            win_idx_q       <= win_idx_d;
            width_q         <= width_d;
            height_q        <= height_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            reset_display_q <= reset_display_d;
            dcm_q           <= dcm_d;
            stb_q           <= stb_d;
            rs_q            <= rs_d;
            data_q          <= data_d;
            num_pixels_q    <= num_pixels_d;
        end
    end

    assign o_busy              = busy_q;
    assign o_done              = done_q;
    assign o_error             = error_q;
    assign o_reset_display     = reset_display_q;
    assign o_data_command_mode = dcm_q;
    assign o_cmd_write_stb     = stb_q;
    assign o_cmd_rs            = rs_q;
    assign o_cmd_data          = data_q;
    assign o_num_pixels        = num_pixels_q;

endmodule

// File: tb/tb_nh_lcd_sequencer.sv
// Self-checking bench for nh_lcd_sequencer: a table of frame requests run
// back to back, then hand-written sequences for stream-time start, reset
// mid-sequence, byte timeout and a full script with no end entry.

module tb_nh_lcd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_frame_only;
    logic        i_script_we;
    logic [3:0]  i_script_addr;
    logic [9:0]  i_script_data;
    logic [15:0] i_width;
    logic [15:0] i_height;
    logic        i_frame_end;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic        o_reset_display;
    logic        o_data_command_mode;
    logic        o_cmd_write_stb;
    logic        o_cmd_rs;
    logic [7:0]  o_cmd_data;
    logic        i_cmd_finished = 1'b0;
    logic [31:0] o_num_pixels;

    always #5 clk = ~clk;

    nh_lcd_sequencer #(
        .RESET_CYCLES  (4),
        .WAKE_CYCLES   (8),
        .SCRIPT_AW     (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_frame_only       (i_frame_only),
        .i_script_we        (i_script_we),
        .i_script_addr      (i_script_addr),
        .i_script_data      (i_script_data),
        .i_width            (i_width),
        .i_height           (i_height),
        .i_frame_end        (i_frame_end),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_error            (o_error),
        .o_reset_display    (o_reset_display),
        .o_data_command_mode(o_data_command_mode),
        .o_cmd_write_stb    (o_cmd_write_stb),
        .o_cmd_rs           (o_cmd_rs),
        .o_cmd_data         (o_cmd_data),
        .i_cmd_finished     (i_cmd_finished),
        .o_num_pixels       (o_num_pixels)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor / responder state (written only by the monitor process).
    int         cyc_total  = 0;
    int         stb_total  = 0;
    int         rd_total   = 0;
    int         done_total = 0;
    int         fin_cd     = 0;
    logic [8:0] log_byte [512];
    int         log_cyc  [512];
    bit         auto_fin = 1'b1;

    // Samples 1 ns after each rising edge; answers each strobe with a
    // finished pulse two cycles later when auto_fin is set.
    always @(posedge clk) begin
        #1;
        cyc_total++;
        if (fin_cd > 0) begin
            fin_cd--;
            i_cmd_finished = (fin_cd == 0);
        end else begin
            i_cmd_finished = 1'b0;
        end
        if (o_cmd_write_stb) begin
            if (stb_total < 512) begin
                log_byte[stb_total] = {o_cmd_rs, o_cmd_data};
                log_cyc[stb_total]  = cyc_total;
            end
            stb_total++;
            if (auto_fin) fin_cd = 2;
        end
        if (o_reset_display) rd_total++;
        if (o_done) done_total++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic start_seq(input logic fo, input logic [15:0] w, input logic [15:0] h);
        i_frame_only = fo;
        i_width      = w;
        i_height     = h;
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_stream(input int bound);
        int i = 0;
        while (!o_data_command_mode && o_busy && i < bound) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic wait_stb(input int target, input int bound);
        int i = 0;
        while (stb_total < target && i < bound) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic end_frame(input string name);
        int d0;
        d0 = done_total;
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
        chk({name, "_done_busy_dcm"}, {o_done, o_busy, o_data_command_mode}, 3'b100);
        chk({name, "_done_count"}, done_total - d0, 1);
    endtask

    task automatic wr_script(input logic [3:0] a, input logic [9:0] d);
        i_script_we   = 1'b1;
        i_script_addr = a;
        i_script_data = d;
        @(negedge clk);
        i_script_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {o_busy, o_done, o_error, o_reset_display, o_data_command_mode,
                   o_cmd_write_stb, o_cmd_rs, o_cmd_data, o_num_pixels}, 0);
    endtask

    typedef struct {
        logic        fo;
        logic [15:0] w;
        logic [15:0] h;
        logic [31:0] np;
        logic        err;
        int          nstb;
        int          nrd;
        logic [7:0]  whi;
        logic [7:0]  wlo;
        logic [7:0]  hhi;
        logic [7:0]  hlo;
        logic        full;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int s0, r0, d0, t0, el, n;
        logic [8:0] ew [11];

        rst = 1'b1;
        i_start = 1'b0; i_frame_only = 1'b0; i_script_we = 1'b0; i_script_addr = 4'd0;
        i_script_data = 10'd0; i_width = 16'd0; i_height = 16'd0; i_frame_end = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;

        // Init script: SLPOUT, wait 256, DISPON, then a parameter byte, end.
        wr_script(4'd0, {2'b00, 8'h11});
        wr_script(4'd1, {2'b10, 8'h01});
        wr_script(4'd2, {2'b00, 8'h29});
        wr_script(4'd3, {2'b01, 8'h05});
        wr_script(4'd4, {2'b11, 8'h00});

        // frame_end while idle must not complete anything.
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
        chk("frame_end_idle", {o_done, o_busy}, 2'b00);

        vecs[0] = '{fo: 1'b0, w: 16'd320, h: 16'd240, np: 32'd76800, err: 1'b0, nstb: 14,
                    nrd: 4, whi: 8'h01, wlo: 8'h3F, hhi: 8'h00, hlo: 8'hEF, full: 1'b1};
        vecs[1] = '{fo: 1'b1, w: 16'd1, h: 16'd1, np: 32'd1, err: 1'b0, nstb: 11,
                    nrd: 0, whi: 8'h00, wlo: 8'h00, hhi: 8'h00, hlo: 8'h00, full: 1'b0};
        vecs[2] = '{fo: 1'b1, w: 16'd320, h: 16'd0, np: 32'd0, err: 1'b1, nstb: 0,
                    nrd: 0, whi: 8'h00, wlo: 8'h00, hhi: 8'h00, hlo: 8'h00, full: 1'b0};
        vecs[3] = '{fo: 1'b0, w: 16'd0, h: 16'd5, np: 32'd0, err: 1'b1, nstb: 0,
                    nrd: 0, whi: 8'h00, wlo: 8'h00, hhi: 8'h00, hlo: 8'h00, full: 1'b0};
        vecs[4] = '{fo: 1'b1, w: 16'hFFFF, h: 16'hFFFF, np: 32'hFFFE0001, err: 1'b0,
                    nstb: 11, nrd: 0, whi: 8'hFF, wlo: 8'hFE, hhi: 8'hFF, hlo: 8'hFE,
                    full: 1'b0};
        vecs[5] = '{fo: 1'b1, w: 16'd256, h: 16'd2, np: 32'd512, err: 1'b0, nstb: 11,
                    nrd: 0, whi: 8'h00, wlo: 8'hFF, hhi: 8'h00, hlo: 8'h01, full: 1'b0};

        // Vectors run back to back: each start lands the cycle after the
        // previous o_done or o_error.
        for (int v = 0; v < 6; v++) begin
            s0 = stb_total;
            r0 = rd_total;
            start_seq(vecs[v].fo, vecs[v].w, vecs[v].h);
            chk($sformatf("v%0d_busy_done_err", v), {o_busy, o_done, o_error}, 3'b100);
            chk($sformatf("v%0d_num_pixels", v), o_num_pixels, vecs[v].np);
            if (vecs[v].err) begin
                @(negedge clk);
                chk($sformatf("v%0d_err_busy", v), {o_error, o_busy}, 2'b10);
                chk($sformatf("v%0d_strobes", v), stb_total - s0, 0);
            end else begin
                wait_stream(3000);
                chk($sformatf("v%0d_stream", v), o_data_command_mode, 1'b1);
                chk($sformatf("v%0d_strobes", v), stb_total - s0, vecs[v].nstb);
                chk($sformatf("v%0d_rst_cycles", v), rd_total - r0, vecs[v].nrd);
                ew = '{9'h02A, 9'h100, 9'h100, {1'b1, vecs[v].whi}, {1'b1, vecs[v].wlo},
                       9'h02B, 9'h100, 9'h100, {1'b1, vecs[v].hhi}, {1'b1, vecs[v].hlo},
                       9'h02C};
                n = s0 + vecs[v].nstb - 11;
                for (int k = 0; k < 11; k++) begin
                    chk($sformatf("v%0d_win%0d", v, k), log_byte[n + k], ew[k]);
                end
                if (vecs[v].full) begin
                    chk("v0_script0", log_byte[s0], 9'h011);
                    chk("v0_script1", log_byte[s0 + 1], 9'h029);
                    chk("v0_script2", log_byte[s0 + 2], 9'h105);
                    el = log_cyc[s0 + 1] - log_cyc[s0];
                    chk("v0_delay_gap_ok", (el >= 256 && el <= 270), 1'b1);
                end
                end_frame($sformatf("v%0d", v));
            end
        end

        // i_start during STREAM is ignored; then rst while streaming.
        s0 = stb_total;
        start_seq(1'b1, 16'd3, 16'd4);
        wait_stream(500);
        chk("strm_reach", o_data_command_mode, 1'b1);
        s0 = stb_total;
        i_width = 16'd5; i_height = 16'd5; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("strm_start_ignored_np", o_num_pixels, 32'd12);
        chk("strm_start_ignored_state", {o_busy, o_data_command_mode}, 2'b11);
        chk("strm_start_ignored_stb", stb_total - s0, 0);
        d0 = done_total;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst_in_stream");
        @(negedge clk);
        chk("rst_in_stream_no_done", done_total - d0, 0);

        // Restart goes through RST_ASSERT; rst again during the first CMD_WAIT.
        s0 = stb_total;
        start_seq(1'b0, 16'd2, 16'd2);
        chk("restart_rst_assert", o_reset_display, 1'b1);
        wait_stb(s0 + 1, 200);
        chk("restart_first_stb", stb_total - s0, 1);
        chk("restart_first_byte", log_byte[s0], 9'h011);
        d0 = done_total;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst_in_cmd_wait");
        repeat (4) @(negedge clk);
        chk("rst_in_cmd_wait_idle", {o_busy, o_cmd_write_stb, done_total - d0 == 0}, 3'b001);

        // Timeout: finished never comes.
        auto_fin = 1'b0;
        s0 = stb_total;
        d0 = done_total;
        start_seq(1'b1, 16'd1, 16'd1);
        wait_stb(s0 + 1, 50);
        chk("to_first_byte", log_byte[s0], 9'h02A);
        t0 = log_cyc[s0];
        n = 0;
        while (!o_error && n < 60) begin
            @(negedge clk);
            n++;
        end
        el = cyc_total - t0;
        chk("to_error_set", o_error, 1'b1);
        chk("to_latency_ok", (el >= 16 && el <= 18), 1'b1);
        chk("to_busy_done", {o_busy, o_done, done_total - d0 == 0}, 3'b001);
        chk("to_single_stb", stb_total - s0, 1);
        auto_fin = 1'b1;
        start_seq(1'b1, 16'd2, 16'd2);
        chk("to_error_cleared", {o_busy, o_error}, 2'b10);
        wait_stream(500);
        chk("to_recover_stream", o_data_command_mode, 1'b1);
        end_frame("to_recover");

        // Full 16-entry script with no end entry: no pointer wrap.
        for (int i = 0; i < 16; i++) begin
            wr_script(4'(i), {1'b0, 1'(i & 1), 8'(128 + i)});
        end
        s0 = stb_total;
        start_seq(1'b0, 16'd2, 16'd3);
        wait_stream(3000);
        chk("full_script_stream", o_data_command_mode, 1'b1);
        chk("full_script_strobes", stb_total - s0, 27);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("full_script_b%0d", k), log_byte[s0 + k], {1'(k & 1), 8'(128 + k)});
        end
        chk("full_script_win0", log_byte[s0 + 16], 9'h02A);
        chk("full_script_wlo", log_byte[s0 + 20], 9'h101);
        chk("full_script_hlo", log_byte[s0 + 25], 9'h102);
        chk("full_script_ramwr", log_byte[s0 + 26], 9'h02C);
        end_frame("full_script");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
